// File: rtl/ctrl_aut.sv
// Multi-cycle controller: FETCH/DECODE/EXEC per instruction, HALT on illegal opcode/funct.
// Outputs are combinational from state and latched ir_op/ir_fn; no backpressure, one instruction per 3 cycles.
// Optional CTRL_AUT_RETIRE_CNT_EN: enables the 32-bit retired-instruction counter (otherwise retired is 0).
module ctrl_aut (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        rd_mux_s,
    output logic        write,
    output logic        op2_mux_s,
    output logic [5:0]  alu_funct,
    output logic        branch_mux_s,
    output logic        pc_en,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] ir_op_q, ir_op_d;
    logic [5:0] ir_fn_q, ir_fn_d;

    logic       dec_legal;
    logic       dec_beq;
    logic       dec_rd;
    logic       dec_op2;
    logic [5:0] dec_alu;

    // Decode looks only at the latched instruction, so live opcode/funct are ignored after FETCH.
    always_comb begin
        dec_legal = 1'b0;
        dec_beq   = 1'b0;
        dec_rd    = 1'b0;
        dec_op2   = 1'b0;
        dec_alu   = 6'h00;
        case (ir_op_q)
            6'h00: begin
                if (ir_fn_q == 6'h20 || ir_fn_q == 6'h22 || ir_fn_q == 6'h24 ||
                    ir_fn_q == 6'h25 || ir_fn_q == 6'h2A) begin
                    dec_legal = 1'b1;
                    dec_rd    = 1'b1;
                    dec_alu   = ir_fn_q;
                end
            end
            6'h08: begin
                dec_legal = 1'b1;
                dec_op2   = 1'b1;
                dec_alu   = 6'h20;
            end
            6'h04: begin
                dec_legal = 1'b1;
                dec_beq   = 1'b1;
                dec_alu   = 6'h22;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ir_op_d      = ir_op_q;
        ir_fn_d      = ir_fn_q;
        rd_mux_s     = 1'b0;
        write        = 1'b0;
        op2_mux_s    = 1'b0;
        alu_funct    = 6'h00;
        branch_mux_s = 1'b0;
        pc_en        = 1'b0;
        halted       = 1'b0;
        case (state_q)
            FETCH: begin
                ir_op_d = opcode;
                ir_fn_d = funct;
                state_d = DECODE;
            end
            DECODE: begin
                rd_mux_s  = dec_rd;
                op2_mux_s = dec_op2;
                alu_funct = dec_alu;
                state_d   = dec_legal ? EXEC : HALT;
            end
            EXEC: begin
                rd_mux_s     = dec_rd;
                op2_mux_s    = dec_op2;
                alu_funct    = dec_alu;
                write        = ~dec_beq;
                branch_mux_s = dec_beq & zero;
                pc_en        = 1'b1;
                state_d      = FETCH;
            end
            HALT: begin
                halted  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FETCH;
            ir_op_q <= 6'h00;
            ir_fn_q <= 6'h00;
        end else begin
            state_q <= state_d;
            ir_op_q <= ir_op_d;
            ir_fn_q <= ir_fn_d;
        end
    end

`ifdef CTRL_AUT_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (state_q == EXEC) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_aut.sv
// Directed bench for ctrl_aut: inputs driven and outputs sampled on the falling clock edge.
module tb_ctrl_aut;

    logic        clock;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        rd_mux_s;
    logic        write;
    logic        op2_mux_s;
    logic [5:0]  alu_funct;
    logic        branch_mux_s;
    logic        pc_en;
    logic        halted;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

`ifdef CTRL_AUT_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    ctrl_aut dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .rd_mux_s     (rd_mux_s),
        .write        (write),
        .op2_mux_s    (op2_mux_s),
        .alu_funct    (alu_funct),
        .branch_mux_s (branch_mux_s),
        .pc_en        (pc_en),
        .halted       (halted),
        .retired      (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ret(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic chk_idle(input string tag, input int n_ret);
        chk({tag, ".rd"},     {31'd0, rd_mux_s},     32'd0);
        chk({tag, ".wr"},     {31'd0, write},        32'd0);
        chk({tag, ".op2"},    {31'd0, op2_mux_s},    32'd0);
        chk({tag, ".alu"},    {26'd0, alu_funct},    32'd0);
        chk({tag, ".br"},     {31'd0, branch_mux_s}, 32'd0);
        chk({tag, ".pc"},     {31'd0, pc_en},        32'd0);
        chk({tag, ".halt"},   {31'd0, halted},       32'd0);
        chk({tag, ".ret"},    retired,               exp_ret(n_ret));
    endtask

    initial begin
        reset  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
        cyc(); cyc();
        chk_idle("reset", 0);

        // ADD, with opcode disturbed after FETCH
        reset  = 1'b1;
        opcode = 6'h00; funct = 6'h20;
        cyc();
        chk("add.dec.rd",  {31'd0, rd_mux_s},  32'd1);
        chk("add.dec.op2", {31'd0, op2_mux_s}, 32'd0);
        chk("add.dec.alu", {26'd0, alu_funct}, 32'h20);
        chk("add.dec.wr",  {31'd0, write},     32'd0);
        chk("add.dec.pc",  {31'd0, pc_en},     32'd0);
        opcode = 6'h3F; funct = 6'h3F;
        cyc();
        chk("add.ex.wr",  {31'd0, write},        32'd1);
        chk("add.ex.pc",  {31'd0, pc_en},        32'd1);
        chk("add.ex.br",  {31'd0, branch_mux_s}, 32'd0);
        chk("add.ex.alu", {26'd0, alu_funct},    32'h20);
        chk("add.ex.rd",  {31'd0, rd_mux_s},     32'd1);
        opcode = 6'h08; funct = 6'h00;
        cyc();
        chk_idle("add.fetch", 1);

        // ADDI
        cyc(); cyc();
        chk("addi.ex.wr",  {31'd0, write},     32'd1);
        chk("addi.ex.op2", {31'd0, op2_mux_s}, 32'd1);
        chk("addi.ex.rd",  {31'd0, rd_mux_s},  32'd0);
        chk("addi.ex.alu", {26'd0, alu_funct}, 32'h20);
        chk("addi.ex.pc",  {31'd0, pc_en},     32'd1);
        opcode = 6'h04; zero = 1'b1;
        cyc();

        // BEQ taken
        cyc();
        chk("beq1.dec.br", {31'd0, branch_mux_s}, 32'd0);
        cyc();
        chk("beq1.ex.br",  {31'd0, branch_mux_s}, 32'd1);
        chk("beq1.ex.wr",  {31'd0, write},        32'd0);
        chk("beq1.ex.pc",  {31'd0, pc_en},        32'd1);
        chk("beq1.ex.alu", {26'd0, alu_funct},    32'h22);
        zero = 1'b0;
        cyc();
        chk("beq1.fetch.br", {31'd0, branch_mux_s}, 32'd0);

        // BEQ not taken
        cyc(); cyc();
        chk("beq0.ex.br",  {31'd0, branch_mux_s}, 32'd0);
        chk("beq0.ex.wr",  {31'd0, write},        32'd0);
        chk("beq0.ex.pc",  {31'd0, pc_en},        32'd1);
        chk("beq0.ex.alu", {26'd0, alu_funct},    32'h22);
        opcode = 6'h3F;
        cyc();

        // Illegal opcode halts until reset
        cyc();
        chk("ill.dec.halt", {31'd0, halted}, 32'd0);
        opcode = 6'h00; funct = 6'h20;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("ill.halt", {31'd0, halted}, 32'd1);
            chk("ill.pc",   {31'd0, pc_en},  32'd0);
            chk("ill.wr",   {31'd0, write},  32'd0);
        end
        chk("ill.ret", retired, exp_ret(4));
        reset = 1'b0;
        cyc();
        chk_idle("ill.reset", 0);

        // Reset in EXEC abandons the ADD
        reset = 1'b1;
        cyc(); cyc();
        chk("ab.ex.wr", {31'd0, write}, 32'd1);
        reset = 1'b0;
        cyc();
        chk_idle("ab.after", 0);

        // SLT, then an illegal R-type funct
        reset = 1'b1;
        opcode = 6'h00; funct = 6'h2A;
        cyc();
        chk("slt.dec.alu", {26'd0, alu_funct}, 32'h2A);
        cyc();
        chk("slt.ex.wr",   {31'd0, write},     32'd1);
        funct = 6'h21;
        cyc();
        chk("slt.ret", retired, exp_ret(1));
        cyc(); cyc();
        chk("badfn.halt", {31'd0, halted}, 32'd1);
        chk("badfn.alu",  {26'd0, alu_funct}, 32'd0);
        reset = 1'b0;
        cyc();
        chk_idle("badfn.reset", 0);

`ifdef CTRL_AUT_RETIRE_CNT_EN
        // Counter wraps from all-ones
        reset = 1'b1;
        opcode = 6'h00; funct = 6'h20;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        cyc(); cyc(); cyc();
        chk("wrap.ret", retired, 32'h0000_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
